ring_eject: RTL and testbench

RING_EJECT -- requirements
Module: ring_eject

---
 rtl/ring_eject_pkg.sv | 40 ++++
 rtl/ring_eject_flit_fifo.sv | 75 +++++++
 rtl/ring_eject.sv | 92 +++++++++
 tb/tb_ring_eject.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ring_eject_pkg.sv
// Shared ring definitions: flit width/field macros, null flit, routing types.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// The macros below are the shared flit defines used by every ring block; they
// are kept in this file so that any block importing the package also sees them.
`ifndef RING_FLIT_DEFINES
`define RING_FLIT_DEFINES
`define CONTROL_W      128
`define FLIT_VALID_BIT 127
`define FLIT_DEST_MSB  126
`define FLIT_DEST_LSB  120
`define FLIT_PAY_MSB   119
`define FLIT_NULL      {`CONTROL_W{1'b0}}
`endif

package ring_eject_pkg;

  localparam int FLIT_W = `CONTROL_W;
  localparam int DEST_W = `FLIT_DEST_MSB - `FLIT_DEST_LSB + 1;
  localparam int DFL_W  = 16;

  localparam logic [FLIT_W-1:0] NULL_FLIT = `FLIT_NULL;
  localparam logic [DFL_W-1:0]  DFL_MAX   = {DFL_W{1'b1}};

  // What happens to the flit currently on the ring input.
  typedef enum logic [1:0] {
    ROUTE_PASS    = 2'd0,  // not for us (or invalid): forward as-is
    ROUTE_EJECT   = 2'd1,  // for us and room in the eject FIFO
    ROUTE_DEFLECT = 2'd2   // for us but FIFO full: keep it circulating
  } route_e;

  // True when a flit header addresses the given node.
  function automatic logic flit_matches(input logic              valid,
                                        input logic [DEST_W-1:0] dest,
                                        input logic [DEST_W-1:0] node);
    return valid && (dest == node);
  endfunction

endpackage

// File: rtl/ring_eject_flit_fifo.sv
// flit_fifo: DEPTH-entry FIFO for ejected flits, head always presented.
// Latency: a pushed entry is visible on pop_data_o/empty_o the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty.
//
// Ports: clk, rst (async active-high); push_i/push_data_i write side;
//        pop_i read side; pop_data_o head entry; full_o/empty_o/count_o status.
module flit_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Guards are evaluated on the occupancy before the edge, so a push while
  // full is dropped even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ring_eject.sv
// ring_eject: pulls flits addressed to NODE_ID off the ring into an eject FIFO.
// Latency: 1 cycle port0_ci -> port0_co; enqueued flit visible next cycle.
// Backpressure: FIFO full -> local flit is deflected (forwarded) and counted.
//
// Ports: clk, rst (async active-high); port0_ci ring in, port0_co ring out;
//        eject_data/eject_valid/eject_ready node-side handshake;
//        eject_count FIFO occupancy; deflect_cnt saturating deflection count.
module ring_eject
  import ring_eject_pkg::*;
#(
  parameter logic [6:0] NODE_ID = 7'd0,
  parameter int         DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`CONTROL_W-1:0]  port0_ci,
  output logic [`CONTROL_W-1:0]  port0_co,
  output logic [`CONTROL_W-1:0]  eject_data,
  output logic                   eject_valid,
  input  logic                   eject_ready,
  output logic [$clog2(DEPTH):0] eject_count,
  output logic [15:0]            deflect_cnt
);

  logic [FLIT_W-1:0] port0_co_q, port0_co_d;
  logic [DFL_W-1:0]  deflect_q,  deflect_d;

  route_e route;
  logic   is_local;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;

  assign is_local = flit_matches(port0_ci[`FLIT_VALID_BIT],
                                 port0_ci[`FLIT_DEST_MSB:`FLIT_DEST_LSB],
                                 NODE_ID);

  // Route decision uses the FIFO state before the edge; a same-cycle dequeue
  // does not open a slot for the incoming flit.
  always_comb begin
    route = ROUTE_PASS;
    if (is_local) begin
      route = fifo_full ? ROUTE_DEFLECT : ROUTE_EJECT;
    end
  end

  assign fifo_push = (route == ROUTE_EJECT);
  assign fifo_pop  = eject_valid && eject_ready;

  always_comb begin
    port0_co_d = port0_ci;
    deflect_d  = deflect_q;
    case (route)
      ROUTE_EJECT:   port0_co_d = NULL_FLIT;
      ROUTE_DEFLECT: begin
        if (deflect_q != DFL_MAX) deflect_d = deflect_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port0_co_q <= NULL_FLIT;
      deflect_q  <= '0;
    end else begin
      port0_co_q <= port0_co_d;
      deflect_q  <= deflect_d;
    end
  end

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (port0_ci),
    .pop_i       (fifo_pop),
    .pop_data_o  (eject_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (eject_count)
  );

  assign port0_co    = port0_co_q;
  assign eject_valid = !fifo_empty;
  assign deflect_cnt = deflect_q;

endmodule

// File: tb/tb_ring_eject.sv
module tb_ring_eject;

  localparam logic [6:0] NID = 7'd3;
  localparam int         DEP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] port0_ci = '0;
  logic         eject_ready = 1'b0;
  logic [127:0] port0_co;
  logic [127:0] eject_data;
  logic         eject_valid;
  logic [2:0]   eject_count;
  logic [15:0]  deflect_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_eject #(.NODE_ID(NID), .DEPTH(DEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .port0_ci    (port0_ci),
    .port0_co    (port0_co),
    .eject_data  (eject_data),
    .eject_valid (eject_valid),
    .eject_ready (eject_ready),
    .eject_count (eject_count),
    .deflect_cnt (deflect_cnt)
  );

  // Behavioural model: a queue of flits, the last forwarded flit and a count.
  logic [127:0] m_q[$];
  logic [127:0] m_co  = '0;
  int           m_dfl = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_co  = '0;
      m_dfl = 0;
    end else begin
      logic mine;
      logic was_full;
      mine     = port0_ci[127] && (port0_ci[126:120] == NID);
      was_full = (m_q.size() == DEP);
      if (eject_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (mine && !was_full) begin
        m_q.push_back(port0_ci);
        m_co = '0;
      end else begin
        m_co = port0_ci;
        if (mine && m_dfl < 65535) m_dfl = m_dfl + 1;
      end
    end
  end

  function automatic logic [127:0] mk(input logic v, input logic [6:0] d,
                                      input logic [119:0] p);
    return {v, d, p};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [127:0] f, input logic r);
    port0_ci    = f;
    eject_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Per-cycle comparison against the model, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("cyc_co",    port0_co,             m_co);
          chk("cyc_valid", 128'(eject_valid),    128'(m_q.size() != 0));
          chk("cyc_count", 128'(eject_count),    128'(m_q.size()));
          chk("cyc_dfl",   128'(deflect_cnt),    128'(m_dfl));
          if (m_q.size() != 0) chk("cyc_data", eject_data, m_q[0]);
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_co",    port0_co,           128'h0);
    chk("rst_valid", 128'(eject_valid),  128'h0);
    chk("rst_count", 128'(eject_count),  128'h0);
    chk("rst_dfl",   128'(deflect_cnt),  128'h0);
    rst = 1'b0;

    // Idle ring
    drive('0, 1'b0);
    drive('0, 1'b0);
    chk("idle_co",    port0_co,          128'h0);
    chk("idle_valid", 128'(eject_valid), 128'h0);
    chk("idle_dfl",   128'(deflect_cnt), 128'h0);

    // Single local flit ejected
    drive(mk(1'b1, 7'd3, 120'hA5), 1'b0);
    chk("ej_co",    port0_co,          128'h0);
    chk("ej_valid", 128'(eject_valid), 128'h1);
    chk("ej_data",  eject_data,        {1'b1, 7'd3, 120'hA5});
    chk("ej_count", 128'(eject_count), 128'h1);

    // Foreign flit passes untouched
    drive(mk(1'b1, 7'd5, 120'h1234), 1'b0);
    chk("fwd_co",    port0_co,          {1'b1, 7'd5, 120'h1234});
    chk("fwd_count", 128'(eject_count), 128'h1);

    drive('0, 1'b1);
    chk("drain1_count", 128'(eject_count), 128'h0);

    // Invalid flit addressed to us with payload: forwarded, not ejected
    drive(mk(1'b0, 7'd3, 120'hBEEF), 1'b0);
    chk("inv_co",    port0_co,          {1'b0, 7'd3, 120'hBEEF});
    chk("inv_count", 128'(eject_count), 128'h0);

    // Fill past capacity: fifth local flit deflected
    for (int i = 1; i <= 5; i++) drive(mk(1'b1, 7'd3, 120'(i)), 1'b0);
    chk("ovf_co",    port0_co,          {1'b1, 7'd3, 120'd5});
    chk("ovf_dfl",   128'(deflect_cnt), 128'h1);
    chk("ovf_count", 128'(eject_count), 128'h4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 128'(eject_data[119:0]), 128'(i));
      drive('0, 1'b1);
    end
    chk("drain_empty", 128'(eject_valid), 128'h0);

    // Simultaneous enqueue/dequeue across the pointer wrap
    drive(mk(1'b1, 7'd3, 120'd6), 1'b0);
    drive(mk(1'b1, 7'd3, 120'd7), 1'b0);
    for (int i = 8; i <= 10; i++) drive(mk(1'b1, 7'd3, 120'(i)), 1'b1);
    chk("both_count", 128'(eject_count),       128'h2);
    chk("both_head",  128'(eject_data[119:0]), 128'd9);

    // Full + match + dequeue in one cycle: still deflects
    drive(mk(1'b1, 7'd3, 120'd11), 1'b0);
    drive(mk(1'b1, 7'd3, 120'd12), 1'b0);
    drive(mk(1'b1, 7'd3, 120'd13), 1'b1);
    chk("fullpop_co",    port0_co,                {1'b1, 7'd3, 120'd13});
    chk("fullpop_count", 128'(eject_count),       128'h3);
    chk("fullpop_dfl",   128'(deflect_cnt),       128'h2);
    chk("fullpop_head",  128'(eject_data[119:0]), 128'd10);

    // Head holds while not accepted
    drive(mk(1'b1, 7'd5, 120'd55), 1'b0);
    drive(mk(1'b1, 7'd5, 120'd56), 1'b0);
    chk("hold_head", 128'(eject_data[119:0]), 128'd10);

    // Asynchronous reset with two flits queued and a flit in the output reg
    drive('0, 1'b1);
    drive(mk(1'b1, 7'd6, 120'd77), 1'b0);
    chk("pre_rst_count", 128'(eject_count), 128'h2);
    chk("pre_rst_co",    port0_co,          {1'b1, 7'd6, 120'd77});
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(eject_valid), 128'h0);
    chk("arst_co",    port0_co,          128'h0);
    chk("arst_count", 128'(eject_count), 128'h0);
    chk("arst_dfl",   128'(deflect_cnt), 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First flit after reset handled normally
    drive(mk(1'b1, 7'd3, 120'h42), 1'b0);
    chk("post_valid", 128'(eject_valid), 128'h1);
    chk("post_data",  eject_data,        {1'b1, 7'd3, 120'h42});
    chk("post_co",    port0_co,          128'h0);

    // Deflect counter saturation
    for (int i = 0; i < 3; i++) drive(mk(1'b1, 7'd3, 120'(100 + i)), 1'b0);
    for (int i = 0; i < 65540; i++) drive(mk(1'b1, 7'd3, 120'(i)), 1'b0);
    chk("sat_dfl",   128'(deflect_cnt), 128'hFFFF);
    chk("sat_count", 128'(eject_count), 128'h4);
    chk("sat_co",    port0_co,          {1'b1, 7'd3, 120'd65539});

    drive('0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
